// File: rtl/qam16_pkg.sv
// Shared 16QAM definitions: symbol size, amplitude level codes and the
// Gray bit-pair mapping used by both the transmit mapper and receive slicer.
package qam16_pkg;

    localparam int BITS_PER_SYM = 4;

    localparam logic [1:0] LVL_M3 = 2'd0;
    localparam logic [1:0] LVL_M1 = 2'd1;
    localparam logic [1:0] LVL_P1 = 2'd2;
    localparam logic [1:0] LVL_P3 = 2'd3;

    typedef enum logic {
        IDLE,
        ACTIVE
    } tx_state_e;

    function automatic logic [1:0] gray_map(input logic [1:0] pair);
        logic [1:0] lvl;
        unique case (pair)
            2'b00: lvl = LVL_M3;
            2'b01: lvl = LVL_M1;
            2'b11: lvl = LVL_P1;
            2'b10: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/qam16_bit_packer.sv
// Packs serial bits into 4-bit symbols and keeps one mapped symbol
// waiting in a single-entry pending register.
module qam16_bit_packer
    import qam16_pkg::*;
#(
    parameter int GRAY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       load,
    output logic       pend_valid,
    output logic [1:0] pend_i,
    output logic [1:0] pend_q
);

    localparam bit         USE_GRAY = (GRAY != 0);
    localparam logic [1:0] CNT_LAST = 2'(BITS_PER_SYM - 1);

    logic [2:0] shreg;
    logic [1:0] bit_cnt;
    logic       last_bit;
    logic       accept;
    logic [1:0] pair_i;
    logic [1:0] pair_q;

    function automatic logic [1:0] map_pair(input logic [1:0] p);
        return USE_GRAY ? gray_map(p) : p;
    endfunction

    assign last_bit  = (bit_cnt == CNT_LAST);
    // A completing bit may refill pending on the edge the top consumes it.
    assign bit_ready = !last_bit || !pend_valid || load;
    assign accept    = bit_valid && bit_ready;
    assign pair_i    = shreg[2:1];
    assign pair_q    = {shreg[0], bit_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_i     <= '0;
            pend_q     <= '0;
        end else begin
            if (load) begin
                pend_valid <= 1'b0;
            end
            if (accept) begin
                if (last_bit) begin
                    pend_valid <= 1'b1;
                    pend_i     <= map_pair(pair_i);
                    pend_q     <= map_pair(pair_q);
                    bit_cnt    <= '0;
                end else begin
                    shreg   <= {shreg[1:0], bit_in};
                    bit_cnt <= bit_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/qam16_symbol_mapper.sv
// 16QAM symbol mapper: packs bits, Gray-maps to I/Q level codes and holds
// each symbol for SPS clocks ahead of the pulse-shaping filter.
module qam16_symbol_mapper
    import qam16_pkg::*;
#(
    parameter int SPS  = 4,
    parameter int GRAY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [1:0] i_sym,
    output logic [1:0] q_sym,
    output logic       sym_strobe,
    output logic       tx_active,
    output logic       underrun
);

    localparam int               CNT_W    = $clog2(SPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SPS < 4 || SPS > 16) begin : g_bad_sps
            $error("qam16_symbol_mapper: SPS must be within 4..16");
        end
    endgenerate

    tx_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       i_n, q_n;
    logic             strobe_n, underrun_n;
    logic             load;
    logic             pend_valid;
    logic [1:0]       pend_i, pend_q;

    qam16_bit_packer #(
        .GRAY (GRAY)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .load       (load),
        .pend_valid (pend_valid),
        .pend_i     (pend_i),
        .pend_q     (pend_q)
    );

    assign tx_active = (state == ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            i_sym      <= '0;
            q_sym      <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            i_sym      <= i_n;
            q_sym      <= q_n;
            sym_strobe <= strobe_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        i_n        = i_sym;
        q_n        = q_sym;
        strobe_n   = 1'b0;
        underrun_n = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    load     = 1'b1;
                    state_n  = ACTIVE;
                    cnt_n    = '0;
                    i_n      = pend_i;
                    q_n      = pend_q;
                    strobe_n = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + CNT_ONE;
                end else if (pend_valid) begin
                    load     = 1'b1;
                    cnt_n    = '0;
                    i_n      = pend_i;
                    q_n      = pend_q;
                    strobe_n = 1'b1;
                end else begin
                    state_n    = IDLE;
                    underrun_n = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Scoreboard bench for qam16_symbol_mapper: SPS=4 Gray, SPS=4 natural
// binary (sharing the same bit stream) and SPS=8 Gray under backpressure.
module tb_qam16_symbol_mapper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in_b = 1'b0;
    logic       bit_valid_b = 1'b0;

    logic       ready_a, strobe_a, tx_a, und_sig_a;
    logic [1:0] i_a, q_a;
    logic       ready_c, strobe_c, tx_c, und_sig_c;
    logic [1:0] i_c, q_c;
    logic       ready_b, strobe_b, tx_b, und_sig_b;
    logic [1:0] i_b, q_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] qc[$];
    logic [3:0] ea, eb, ec;
    logic [3:0] sym_ac = '0;
    logic [3:0] sym_b = '0;
    int nb_ac = 0;
    int nb_b = 0;
    int stalls_b = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    int strobes_c = 0;
    int und_a = 0;
    int und_b = 0;
    int cyc = 0;
    int last_a = 0;
    bit last_a_ok = 1'b0;
    bit chk_gap = 1'b0;
    int s0, u0;

    always #5 clk = ~clk;

    qam16_symbol_mapper #(.SPS(4), .GRAY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(ready_a), .i_sym(i_a), .q_sym(q_a), .sym_strobe(strobe_a),
        .tx_active(tx_a), .underrun(und_sig_a)
    );

    qam16_symbol_mapper #(.SPS(4), .GRAY(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(ready_c), .i_sym(i_c), .q_sym(q_c), .sym_strobe(strobe_c),
        .tx_active(tx_c), .underrun(und_sig_c)
    );

    qam16_symbol_mapper #(.SPS(8), .GRAY(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in_b), .bit_valid(bit_valid_b),
        .bit_ready(ready_b), .i_sym(i_b), .q_sym(q_b), .sym_strobe(strobe_b),
        .tx_active(tx_b), .underrun(und_sig_b)
    );

    function automatic logic [1:0] gmap(input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b11:   r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_ac(input logic b);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        bit_in = b;
        bit_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            check("ac_accept_timeout", 32'(acc), 32'(1));
        end else begin
            sym_ac = {sym_ac[2:0], b};
            nb_ac++;
            if (nb_ac == 4) begin
                qa.push_back({gmap(sym_ac[3:2]), gmap(sym_ac[1:0])});
                qc.push_back(sym_ac);
                nb_ac = 0;
            end
        end
    endtask

    task automatic send_b(input logic b);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        bit_in_b = b;
        bit_valid_b = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = ready_b;
            if (!acc) stalls_b++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            check("b_accept_timeout", 32'(acc), 32'(1));
        end else begin
            sym_b = {sym_b[2:0], b};
            nb_b++;
            if (nb_b == 4) begin
                qb.push_back({gmap(sym_b[3:2]), gmap(sym_b[1:0])});
                nb_b = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (strobe_a) begin
                strobes_a++;
                if (qa.size() == 0) begin
                    check("a_unexpected_symbol", 32'(1), 32'(0));
                end else begin
                    ea = qa.pop_front();
                    check("a_i_sym", 32'(i_a), 32'(ea[3:2]));
                    check("a_q_sym", 32'(q_a), 32'(ea[1:0]));
                end
                if (chk_gap && last_a_ok) check("a_strobe_spacing", 32'(cyc - last_a), 32'(4));
                last_a = cyc;
                last_a_ok = 1'b1;
            end
            if (und_sig_a) und_a++;
            if (strobe_c) begin
                strobes_c++;
                if (qc.size() == 0) begin
                    check("c_unexpected_symbol", 32'(1), 32'(0));
                end else begin
                    ec = qc.pop_front();
                    check("c_i_sym", 32'(i_c), 32'(ec[3:2]));
                    check("c_q_sym", 32'(q_c), 32'(ec[1:0]));
                end
            end
            if (strobe_b) begin
                strobes_b++;
                if (qb.size() == 0) begin
                    check("b_unexpected_symbol", 32'(1), 32'(0));
                end else begin
                    eb = qb.pop_front();
                    check("b_i_sym", 32'(i_b), 32'(eb[3:2]));
                    check("b_q_sym", 32'(q_b), 32'(eb[1:0]));
                end
            end
            if (und_sig_b) und_b++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_sym", 32'(i_a), 32'(0));
        check("rst_q_sym", 32'(q_a), 32'(0));
        check("rst_strobe", 32'(strobe_a), 32'(0));
        check("rst_tx_active", 32'(tx_a), 32'(0));
        check("rst_underrun", 32'(und_sig_a), 32'(0));
        check("rst_ready", 32'(ready_a), 32'(1));
        check("rst_ready_b", 32'(ready_b), 32'(1));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // partial symbol, then reset mid-stream
        send_ac(1'b1);
        send_ac(1'b1);
        reset_n = 1'b0;
        bit_valid = 1'b0;
        nb_ac = 0;
        sym_ac = '0;
        #2;
        check("midrst_tx_active", 32'(tx_a), 32'(0));
        check("midrst_strobe", 32'(strobe_a), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready_a), 32'(1));

        // single symbol 1,0,0,1 -> I=3, Q=1, held 4 clocks then underrun
        send_ac(1'b1);
        send_ac(1'b0);
        send_ac(1'b0);
        send_ac(1'b1);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        check("single_strobe", 32'(strobe_a), 32'(1));
        check("single_i", 32'(i_a), 32'(3));
        check("single_q", 32'(q_a), 32'(1));
        check("single_tx", 32'(tx_a), 32'(1));
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            check("hold_strobe_low", 32'(strobe_a), 32'(0));
            check("hold_tx", 32'(tx_a), 32'(1));
            check("hold_i", 32'(i_a), 32'(3));
        end
        @(posedge clk);
        #1;
        check("end_underrun", 32'(und_sig_a), 32'(1));
        check("end_tx_low", 32'(tx_a), 32'(0));
        @(posedge clk);
        #1;
        check("underrun_one_cycle", 32'(und_sig_a), 32'(0));
        check("idle_hold_q", 32'(q_a), 32'(1));

        // 1,1,1,0: Gray -> I=2,Q=3; natural -> I=3,Q=2
        send_ac(1'b1);
        send_ac(1'b1);
        send_ac(1'b1);
        send_ac(1'b0);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gray_i", 32'(i_a), 32'(2));
        check("gray_q", 32'(q_a), 32'(3));
        check("natural_i", 32'(i_c), 32'(3));
        check("natural_q", 32'(q_c), 32'(2));
        repeat (6) @(posedge clk);
        #1;

        // gap underrun between two symbols
        s0 = strobes_a;
        u0 = und_a;
        send_ac(1'b0);
        send_ac(1'b1);
        send_ac(1'b1);
        send_ac(1'b1);
        bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_ac(1'b1);
        send_ac(1'b0);
        check("gap_tx_low", 32'(tx_a), 32'(0));
        check("gap_underrun", 32'(und_sig_a), 32'(1));
        send_ac(1'b0);
        send_ac(1'b0);
        bit_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("gap_underrun_count", 32'(und_a - u0), 32'(2));
        check("gap_strobe_count", 32'(strobes_a - s0), 32'(2));

        // continuous stream, 64 random bits at SPS=4
        s0 = strobes_a;
        u0 = und_a;
        last_a_ok = 1'b0;
        chk_gap = 1'b1;
        for (int k = 0; k < 64; k++) send_ac(1'($urandom_range(0, 1)));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_gap = 1'b0;
        check("stream_strobe_count", 32'(strobes_a - s0), 32'(16));
        check("stream_no_underrun", 32'(und_a - u0), 32'(0));
        bit_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // backpressure at SPS=8: 100 symbols
        for (int k = 0; k < 400; k++) send_b(1'($urandom_range(0, 1)));
        bit_valid_b = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_strobe_count", 32'(strobes_b), 32'(100));
        check("bp_stalled", 32'(stalls_b > 0), 32'(1));
        check("bp_underrun_count", 32'(und_b), 32'(1));
        check("qb_drained", 32'(qb.size()), 32'(0));
        check("qa_drained", 32'(qa.size()), 32'(0));
        check("qc_drained", 32'(qc.size()), 32'(0));
        check("c_strobe_count", 32'(strobes_c), 32'(strobes_a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
